lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, SHALL set the byte-address width of the memory port.
REQ-002 Parameter WAIT_CYCLES, default 0, SHALL set the extra cycles the ACCESS state is held for slow memories (0..15).
REQ-003 clk  input  1  SHALL be the clock; all state updates on posedge.
REQ-004 clr  input  1  SHALL be the reset, asynchronous, active-high.
REQ-005 req_valid  input  1  SHALL indicate a CPU load/store request.
REQ-006 req_ready  output  1  SHALL indicate the block accepts a request this cycle.
REQ-007 req_we  input  1  SHALL select store (1) or load (0).
REQ-008 req_size  input  2  SHALL select the access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 req_unsigned  input  1  SHALL select zero-extension (1) or sign-extension (0) for byte/halfword loads.
REQ-010 req_addr  input  ADDR_WIDTH  SHALL be the byte address.
REQ-011 req_wdata  input  32  SHALL be the store data, right-aligned.
REQ-012 resp_valid  output  1  SHALL be a one-cycle completion pulse.
REQ-013 resp_rdata  output  32  SHALL be the extended load data, 0 for stores and errors.
REQ-014 resp_err  output  1  SHALL flag a misaligned or illegal-size request, valid with resp_valid.
REQ-015 ram_addr/ram_din/ram_mode/ram_str/ram_sel/ram_ld  outputs  ADDR_WIDTH/32/2/1/1/1  SHALL drive the word-organized RAM port (mode 00 byte, 01 half, 10 word).
REQ-016 ram_dout  input  32  SHALL be the RAM's combinational read data, right-aligned and zero-filled for byte/halfword mode.

Function
REQ-017 The FSM SHALL have the states IDLE, ACCESS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 On req_valid & req_ready, the block SHALL register we/size/unsigned/addr/wdata and go to ACCESS, or go directly to RESP with err=1 if the request is misaligned.
REQ-019 A request SHALL be misaligned if size=01 with addr[0]=1, size=10 with addr[1:0]!=0, or size=11.
REQ-020 ACCESS SHALL last WAIT_CYCLES+1 cycles, counted by a 4-bit down-counter loaded on accept; ram_sel SHALL be 1 throughout ACCESS and 0 elsewhere.
REQ-021 ram_addr, ram_mode and ram_din SHALL be driven from the registered request during ACCESS and SHALL be 0 otherwise.
REQ-022 ram_str SHALL be 1 only in the final ACCESS cycle of a store, giving exactly one write edge per store.
REQ-023 For a load, ram_dout SHALL be sampled in the final ACCESS cycle: byte extends bit 7, half extends bit 15, word passes through, and req_unsigned forces zero-fill.
REQ-024 RESP SHALL last exactly one cycle with resp_valid=1 and then return to IDLE; resp_rdata and resp_err SHALL hold until the next resp_valid.
REQ-025 Latency from the accept edge to resp_valid SHALL be WAIT_CYCLES+2 cycles for valid requests and 1 cycle for errored requests.
REQ-026 Throughput SHALL be one request per WAIT_CYCLES+3 cycles; req_valid outside IDLE SHALL be ignored, with no queuing.
REQ-027 ram_ld SHALL be tied to 1.
REQ-028 An errored request SHALL cause no RAM activity (ram_sel=0, ram_str=0).

Reset
REQ-029 On clr, the block SHALL immediately enter IDLE, zero all registers including the counter, and drive req_ready=1 and all other outputs 0.
REQ-030 A clr asserted during ACCESS SHALL drop ram_str before the next clk edge, so no partial write occurs from this block.
REQ-031 After clr is released, the first accept SHALL occur no earlier than the first clk edge.

Structure
REQ-032 A shared package SHALL hold the MODE_BYTE/MODE_HALF/MODE_WORD constants (matching the RAM) and the state enum {IDLE, ACCESS, RESP}.
REQ-033 The load extension SHALL be a separate combinational sub-module, lsu_extend (inputs: data, size, unsigned; output: 32-bit result).

Verification
REQ-034 Store word 0xDEADBEEF at 0x010, then load word at 0x010 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid 2 cycles after accept (WAIT_CYCLES=0).
REQ-035 Store byte 0x80 at 0x013, then lb 0x013 -> 0xFFFFFF80; lbu 0x013 -> 0x00000080; lw 0x010 -> 0x80ADBEEF.
REQ-036 sh 0x8001 at 0x022, then lh 0x022 -> 0xFFFF8001 and lhu 0x022 -> 0x00008001.
REQ-037 lw at 0x011 and lh at 0x021 -> resp_err=1, resp_rdata=0, resp_valid 1 cycle after accept, ram_sel never high.
REQ-038 WAIT_CYCLES=3, sw 0x12345678 with clr pulsed in the 2nd ACCESS cycle -> ram_str never high and the FSM is in IDLE immediately; with no clr, ram_str is high only in the 4th ACCESS cycle and resp_valid comes 5 cycles after accept.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | lsu_ctrl_pkg : RAM mode encodings, FSM states, alignment helper      |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

package lsu_ctrl_pkg;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_WORD = 2'b10;
  localparam logic [1:0] MODE_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      MODE_BYTE: is_misaligned = 1'b0;
      MODE_HALF: is_misaligned = addr_lo[0];
      MODE_WORD: is_misaligned = (addr_lo != 2'b00);
      default:   is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_ctrl_if.sv
// +--------------------------------------------------------------------+
// | lsu_ctrl_if : CPU request/response bus plus word-organized RAM port  |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

interface lsu_ctrl_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_err;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_din;
  logic [1:0]            ram_mode;
  logic                  ram_str;
  logic                  ram_sel;
  logic                  ram_ld;
  logic [31:0]           ram_dout;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_dout,
    output req_ready, resp_valid, resp_rdata, resp_err,
           ram_addr, ram_din, ram_mode, ram_str, ram_sel, ram_ld
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           ram_addr, ram_din, ram_mode, ram_str, ram_sel, ram_ld
  );
endinterface

`default_nettype wire

// File: rtl/lsu_ctrl_extend.sv
// +--------------------------------------------------------------------+
// | lsu_extend : sign/zero extension of right-aligned load data          |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module lsu_extend
  import lsu_ctrl_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        unsgn,
  output logic [31:0] result
);

  always_comb begin
    case (size)
      MODE_BYTE: result = {{24{data[7] & ~unsgn}}, data[7:0]};
      MODE_HALF: result = {{16{data[15] & ~unsgn}}, data[15:0]};
      default:   result = data;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// +--------------------------------------------------------------------+
// | lsu_ctrl : single-outstanding load/store unit driving a word RAM     |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       clr,
  lsu_ctrl_if.slave  bus
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  lsu_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  req_ready_q, req_ready_d;
  logic                  ram_sel_q, ram_sel_d;
  logic                  ram_str_q, ram_str_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]           ram_din_q, ram_din_d;
  logic [1:0]            ram_mode_q, ram_mode_d;
  logic [31:0]           ext_data;

  lsu_extend u_extend (
    .data   (bus.ram_dout),
    .size   (size_q),
    .unsgn  (uns_q),
    .result (ext_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = WAIT_LOAD;
          if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
            state_d = RESP;
            rdata_d = '0;
            err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'd0 : ext_data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are computed from the next state so they are clean flop outputs.
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
    ram_sel_d    = (state_d == ACCESS);
    ram_str_d    = ram_sel_d && we_d && (cnt_d == 4'd0);
    ram_addr_d   = ram_sel_d ? addr_d  : '0;
    ram_din_d    = ram_sel_d ? wdata_d : '0;
    ram_mode_d   = ram_sel_d ? size_d  : '0;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      req_ready_q  <= 1'b1;
      ram_sel_q    <= 1'b0;
      ram_str_q    <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      ram_mode_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      req_ready_q  <= req_ready_d;
      ram_sel_q    <= ram_sel_d;
      ram_str_q    <= ram_str_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      ram_mode_q   <= ram_mode_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.ram_sel    = ram_sel_q;
  assign bus.ram_str    = ram_str_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_din    = ram_din_q;
  assign bus.ram_mode   = ram_mode_q;
  assign bus.ram_ld     = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_lsu_ctrl : scoreboard bench, byte-array reference model + RAM     |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_lsu_ctrl;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk;
  logic clr0;
  logic clr3;
  int   cyc = 0;
  int   ntotal = 0;
  int   nbad = 0;
  int   n_valid = 0;
  int   n_store = 0;
  int   sel_cycles0 = 0;
  int   str_cycles0 = 0;
  int   str3_rises = 0;
  int   ram3_wr = 0;
  logic [31:0] ram3_word = 32'd0;
  exp_t sbq[$];

  logic [7:0]  mem_ref [4096] = '{default: 8'h00};
  logic [31:0] ram0 [1024]    = '{default: 32'h0};

  lsu_ctrl_if #(.ADDR_WIDTH(12)) bus0 ();
  lsu_ctrl_if #(.ADDR_WIDTH(12)) bus3 ();

  lsu_ctrl #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut0 (.clk(clk), .clr(clr0), .bus(bus0));
  lsu_ctrl #(.ADDR_WIDTH(12), .WAIT_CYCLES(3)) dut3 (.clk(clk), .clr(clr3), .bus(bus3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Word RAM behind dut0: right-aligned, zero-filled reads; lane writes.
  always_comb begin
    logic [31:0] w;
    w = ram0[bus0.ram_addr[11:2]];
    case (bus0.ram_mode)
      2'b00:   bus0.ram_dout = {24'd0, w[8 * bus0.ram_addr[1:0] +: 8]};
      2'b01:   bus0.ram_dout = {16'd0, w[16 * bus0.ram_addr[1] +: 16]};
      default: bus0.ram_dout = w;
    endcase
  end

  always @(posedge clk) begin
    if (bus0.ram_sel && bus0.ram_str) begin
      case (bus0.ram_mode)
        2'b00:   ram0[bus0.ram_addr[11:2]][8 * bus0.ram_addr[1:0] +: 8] <= bus0.ram_din[7:0];
        2'b01:   ram0[bus0.ram_addr[11:2]][16 * bus0.ram_addr[1] +: 16] <= bus0.ram_din[15:0];
        default: ram0[bus0.ram_addr[11:2]] <= bus0.ram_din;
      endcase
    end
  end

  assign bus3.ram_dout = 32'd0;

  always @(posedge clk) begin
    if (bus3.ram_sel && bus3.ram_str) begin
      ram3_word <= bus3.ram_din;
      ram3_wr   <= ram3_wr + 1;
    end
  end

  always @(posedge bus3.ram_str) str3_rises++;

  // Monitor: pops the scoreboard whenever dut0 presents a response.
  always @(negedge clk) begin
    if (!clr0) begin
      if (bus0.ram_sel) sel_cycles0++;
      if (bus0.ram_str) str_cycles0++;
      if (bus0.resp_valid) begin
        ntotal++;
        if (sbq.size() == 0) begin
          nbad++;
          $display("FAIL unexpected_resp: rdata=%h err=%b at cycle %0d, none expected",
                   bus0.resp_rdata, bus0.resp_err, cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (bus0.resp_rdata !== e.rdata || bus0.resp_err !== e.err || cyc != e.cyc) begin
            nbad++;
            $display("FAIL resp: got rdata=%h err=%b cycle=%0d, want rdata=%h err=%b cycle=%0d",
                     bus0.resp_rdata, bus0.resp_err, cyc, e.rdata, e.err, e.cyc);
          end
        end
      end
    end
  end

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit ref_bad(input logic [1:0] sz, input int a);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input int a);
    int     n;
    longint v;
    n = size_bytes(sz);
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(mem_ref[a + i]) << (8 * i);
    if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    ntotal++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [11:0] a, input logic [31:0] wd,
                       input bit has_exp, input logic [31:0] exp_rd);
    exp_t e;
    int   guard;
    bit   bad;
    @(negedge clk);
    guard = 0;
    while (!bus0.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    ntotal++;
    if (!bus0.req_ready) begin
      nbad++;
      $display("FAIL ready_timeout: req_ready=%b after %0d cycles, want 1", bus0.req_ready, guard);
      return;
    end
    bus0.req_valid    = 1'b1;
    bus0.req_we       = we;
    bus0.req_size     = sz;
    bus0.req_unsigned = uns;
    bus0.req_addr     = a;
    bus0.req_wdata    = wd;
    bad     = ref_bad(sz, int'(a));
    e.err   = bad;
    e.cyc   = cyc + (bad ? 1 : 2);
    e.rdata = (bad || we) ? 32'd0 : ref_load(sz, uns, int'(a));
    if (has_exp) e.rdata = exp_rd;
    if (!bad) begin
      n_valid++;
      if (we) begin
        n_store++;
        for (int i = 0; i < size_bytes(sz); i++) mem_ref[int'(a) + i] = wd[8 * i +: 8];
      end
    end
    sbq.push_back(e);
    // One cycle of unrelated traffic while busy; it must be ignored.
    @(negedge clk);
    bus0.req_we       = 1'($urandom);
    bus0.req_size     = 2'($urandom);
    bus0.req_addr     = 12'($urandom);
    bus0.req_wdata    = $urandom;
    @(negedge clk);
    bus0.req_valid    = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sbq.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("drain_queue", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    int          s;
    int          acc;
    int          guard;
    logic [1:0]  rsz;

    clr0 = 1'b1;
    clr3 = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_size = 2'd0;
    bus0.req_unsigned = 1'b0; bus0.req_addr = 12'd0; bus0.req_wdata = 32'd0;
    bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_size = 2'd0;
    bus3.req_unsigned = 1'b0; bus3.req_addr = 12'd0; bus3.req_wdata = 32'd0;

    repeat (3) @(negedge clk);
    check("rst_req_ready",  32'(bus0.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus0.resp_valid), 32'd0);
    check("rst_resp_rdata", bus0.resp_rdata, 32'd0);
    check("rst_resp_err",   32'(bus0.resp_err), 32'd0);
    check("rst_ram_sel",    32'(bus0.ram_sel), 32'd0);
    check("rst_ram_str",    32'(bus0.ram_str), 32'd0);
    check("rst_ram_addr",   32'(bus0.ram_addr), 32'd0);
    check("rst_ram_ld",     32'(bus0.ram_ld), 32'd1);
    clr0 = 1'b0;
    clr3 = 1'b0;

    // Directed sequence on the zero-wait instance.
    issue(1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF, 1, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 1, 32'hDEADBEEF);
    issue(1'b1, 2'd0, 1'b0, 12'h013, 32'h00000080, 1, 32'h0);
    issue(1'b0, 2'd0, 1'b0, 12'h013, 32'h0, 1, 32'hFFFFFF80);
    issue(1'b0, 2'd0, 1'b1, 12'h013, 32'h0, 1, 32'h00000080);
    issue(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 1, 32'h80ADBEEF);
    issue(1'b1, 2'd1, 1'b0, 12'h022, 32'h00008001, 1, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 12'h022, 32'h0, 1, 32'hFFFF8001);
    issue(1'b0, 2'd1, 1'b1, 12'h022, 32'h0, 1, 32'h00008001);
    drain();
    s = sel_cycles0;
    issue(1'b0, 2'd2, 1'b0, 12'h011, 32'h0, 1, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 12'h021, 32'h0, 1, 32'h0);
    issue(1'b1, 2'd3, 1'b0, 12'h020, 32'hFFFFFFFF, 1, 32'h0);
    drain();
    check("err_no_ram_sel", 32'(sel_cycles0), 32'(s));

    // Randomized traffic against the byte-array model.
    for (int k = 0; k < 300; k++) begin
      rsz = 2'($urandom);
      issue(1'($urandom), rsz, 1'($urandom), 12'($urandom_range(0, 63)), $urandom, 0, 32'h0);
    end
    drain();
    check("sel_cycle_count", 32'(sel_cycles0), 32'(n_valid));
    check("str_cycle_count", 32'(str_cycles0), 32'(n_store));

    // Slow-memory instance: reset in the 2nd ACCESS cycle of a store.
    @(negedge clk);
    bus3.req_valid = 1'b1; bus3.req_we = 1'b1; bus3.req_size = 2'd2;
    bus3.req_addr = 12'h040; bus3.req_wdata = 32'h12345678;
    check("w3_ready", 32'(bus3.req_ready), 32'd1);
    @(negedge clk);
    bus3.req_valid = 1'b0;
    check("w3_acc1_sel", 32'(bus3.ram_sel), 32'd1);
    check("w3_acc1_str", 32'(bus3.ram_str), 32'd0);
    @(negedge clk);
    check("w3_acc2_sel", 32'(bus3.ram_sel), 32'd1);
    clr3 = 1'b1;
    #1;
    check("w3_clr_ready", 32'(bus3.req_ready), 32'd1);
    check("w3_clr_sel",   32'(bus3.ram_sel), 32'd0);
    check("w3_clr_str",   32'(bus3.ram_str), 32'd0);
    @(negedge clk);
    clr3 = 1'b0;
    check("w3_clr_no_str",   32'(str3_rises), 32'd0);
    check("w3_clr_no_write", 32'(ram3_wr), 32'd0);

    // Same store without reset: strobe only in the 4th ACCESS cycle.
    @(negedge clk);
    guard = 0;
    while (!bus3.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    bus3.req_valid = 1'b1;
    acc = cyc;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      bus3.req_valid = 1'b0;
      check($sformatf("w3_c%0d_str", k), 32'(bus3.ram_str), 32'(k == 4));
      check($sformatf("w3_c%0d_sel", k), 32'(bus3.ram_sel), 32'(k <= 4));
      check($sformatf("w3_c%0d_resp", k), 32'(bus3.resp_valid), 32'(k == 5));
      check($sformatf("w3_c%0d_cycle", k), 32'(cyc - acc), 32'(k));
      if (k == 5) begin
        check("w3_resp_rdata", bus3.resp_rdata, 32'd0);
        check("w3_resp_err",   32'(bus3.resp_err), 32'd0);
      end
    end
    check("w3_ram_word", ram3_word, 32'h12345678);
    check("w3_write_cnt", 32'(ram3_wr), 32'd1);
    check("w3_str_rises", 32'(str3_rises), 32'd1);
    check("w3_ram_ld", 32'(bus3.ram_ld), 32'd1);

    $display("test done: total=%0d bad=%0d", ntotal, nbad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
